axis_rate_meter: RTL and testbench
==================================

# axis_rate_meter

Passive AXI4-Stream throughput meter: taps a stream's handshake signals without driving them and counts beats, bytes, frames, stall cycles and idle cycles over a programmable window of clock cycles. At each window end it publishes a registered snapshot with a one-cycle strobe. It is the measuring counterpart to the stream rate limiter: it sits on the far side of a limited link or on any internal stream to report achieved rate to control/status registers.

## Interface
- KEEP_WIDTH, 1: tkeep width in bytes per beat.
- KEEP_ENABLE, (KEEP_WIDTH>1): use tkeep for byte counting; if 0, each beat counts KEEP_WIDTH bytes.
- LAST_ENABLE, 1: use tlast for frame counting; if 0, every beat counts as one frame.
- COUNT_WIDTH, 32: width of every accumulator and snapshot output.
- PERIOD_WIDTH, 32: width of the window length input.

Ports:
- clk  in  1  clock; all logic in this single domain.
- rst  in  1  asynchronous, active-high reset.
- mon_axis_tkeep  in  KEEP_WIDTH  tapped tkeep.
- mon_axis_tvalid  in  1  tapped tvalid.
- mon_axis_tready  in  1  tapped tready.
- mon_axis_tlast  in  1  tapped tlast.
- enable  in  1  metering enable.
- period  in  PERIOD_WIDTH  window length in cycles; 0 = halted.
- beat_count  out  COUNT_WIDTH  transfers (tvalid&&tready) in last window.
- byte_count  out  COUNT_WIDTH  bytes transferred in last window.
- frame_count  out  COUNT_WIDTH  transfers with tlast in last window.
- stall_count  out  COUNT_WIDTH  cycles with tvalid&&!tready.
- idle_count  out  COUNT_WIDTH  cycles with !tvalid.
- count_valid  out  1  one-cycle strobe: snapshot outputs updated.
- peak_beat_count  out  COUNT_WIDTH  maximum beat_count since reset/clear (see Configuration).
- clear_peak  in  1  synchronous clear of peak_beat_count.

## Operation
- States: IDLE, RUN. Reset -> IDLE. IDLE -> RUN when enable=1 and period!=0; window length latched as period at that edge. RUN -> IDLE when enable=0 or latched period... (period changes ignored mid-window; re-latched at each window start).
- RUN: cycle counter counts 0..P-1. Each cycle exactly one of transfer, stall, idle is accumulated (tvalid&&tready, tvalid&&!tready, !tvalid). Transfers add 1 beat, popcount(tkeep) bytes (KEEP_ENABLE) or KEEP_WIDTH, and 1 frame if tlast (LAST_ENABLE) or always (!LAST_ENABLE).
- Window end (counter = P-1): that cycle's events belong to the closing window; accumulators + current event copied to snapshot registers; accumulators cleared; counter to 0; new period latched; if new period=0, go IDLE.
- Invariant: stall_count+idle_count+beat_count = P unless saturated.
- All accumulators saturate at 2^COUNT_WIDTH-1; no wrap.
- enable dropped mid-window: partial window discarded, no strobe, accumulators cleared, snapshot outputs hold previous values.
- The block never drives the tapped stream; no back-pressure effect.

## Timing
- Reset values: all counts 0, count_valid 0, peak_beat_count 0, state IDLE.
- Window of P cycles begins the cycle after the IDLE->RUN edge; count_valid high for exactly the one cycle after the window's last cycle, snapshot outputs stable from that cycle until next strobe.
- Back-to-back windows: no dead cycles; strobe period exactly P cycles.
- P=1: strobe every cycle, each snapshot reflects one cycle.
- Reset asserted mid-window: immediate return to reset values, no strobe.

## Configuration
- AXIS_RATE_METER_PEAK_EN defined: peak register updates on each strobe to max(peak, new beat_count); clear_peak sets it to 0 next cycle, and a coincident strobe loads the new beat_count instead (clear wins over old value, not over new window).
- Not defined: peak_beat_count tied to 0, clear_peak ignored, no peak logic synthesized.

## Test plan
- period=10, tvalid=tready=1 continuous, KEEP_WIDTH=4, tkeep=4'hF, tlast every 5th beat -> beat 10, byte 40, frame 2, stall 0, idle 0, strobe every 10 cycles.
- period=8, tvalid=1, tready alternating 1/0, tkeep=4'h3 -> beat 4, byte 8, stall 4, idle 0.
- period=16, stream idle -> idle 16, all others 0; then enable=0 at cycle 7 of next window -> no strobe, outputs hold idle 16.
- COUNT_WIDTH=4, period=100, continuous transfers -> beat_count 15 (saturated), idle 0.
- period changed 10->20 mid-window -> current window still 10 cycles, next strobe 20 cycles later; period=1 -> strobe every cycle.
- PEAK_EN: windows with beats 6, 9, 3 -> peak 9; clear_peak -> 0; next window 3 -> peak 3; without macro peak stays 0.

Source files
------------

// File: rtl/axis_rate_meter.sv
// axis_rate_meter: passive AXI4-Stream meter counting beats, bytes, frames, stalls and idles per window.
// Latency: snapshot outputs and count_valid strobe appear the cycle after a window's last cycle.
// Backpressure: none; observe-only tap. Optional peak tracker enabled by macro AXIS_RATE_METER_PEAK_EN.
module axis_rate_meter #(
   parameter int KEEP_WIDTH   = 1,
   parameter bit KEEP_ENABLE  = (KEEP_WIDTH > 1),
   parameter bit LAST_ENABLE  = 1'b1,
   parameter int COUNT_WIDTH  = 32,
   parameter int PERIOD_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [KEEP_WIDTH-1:0]   mon_axis_tkeep,
   input  logic                    mon_axis_tvalid,
   input  logic                    mon_axis_tready,
   input  logic                    mon_axis_tlast,
   input  logic                    enable,
   input  logic [PERIOD_WIDTH-1:0] period,
   output logic [COUNT_WIDTH-1:0]  beat_count,
   output logic [COUNT_WIDTH-1:0]  byte_count,
   output logic [COUNT_WIDTH-1:0]  frame_count,
   output logic [COUNT_WIDTH-1:0]  stall_count,
   output logic [COUNT_WIDTH-1:0]  idle_count,
   output logic                    count_valid,
   output logic [COUNT_WIDTH-1:0]  peak_beat_count,
   input  logic                    clear_peak
);

   localparam int CW = COUNT_WIDTH;
   localparam int PW = PERIOD_WIDTH;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t          r_state, w_state_nxt;
   logic            w_start, w_run, w_win_end;
   logic [PW-1:0]   r_period, r_cnt;
   logic [CW-1:0]   r_beat_acc, r_byte_acc, r_frame_acc, r_stall_acc, r_idle_acc;
   logic [CW-1:0]   r_beat_snap, r_byte_snap, r_frame_snap, r_stall_snap, r_idle_snap;
   logic            r_count_valid;
   logic            w_xfer, w_stall, w_idle, w_frame;
   logic [CW:0]     w_byte_inc;
   logic [CW-1:0]   w_beat_sum, w_byte_sum, w_frame_sum, w_stall_sum, w_idle_sum;
   logic            w_unused;

   // Add with clamp at all-ones so counters never wrap.
   function automatic logic [CW-1:0] f_sat_add(input logic [CW-1:0] a, input logic [CW:0] b);
      logic [CW+1:0] s;
      s = {2'b00, a} + {1'b0, b};
      if (s > {2'b00, {CW{1'b1}}}) return {CW{1'b1}};
      return s[CW-1:0];
   endfunction

   // Inputs that only matter in some configurations are folded here.
   assign w_unused = ^{clear_peak, mon_axis_tkeep, mon_axis_tlast};

   assign w_xfer  = mon_axis_tvalid & mon_axis_tready;
   assign w_stall = mon_axis_tvalid & ~mon_axis_tready;
   assign w_idle  = ~mon_axis_tvalid;
   assign w_frame = w_xfer & (LAST_ENABLE ? mon_axis_tlast : 1'b1);

   // Bytes carried by this cycle's transfer: popcount of tkeep, or the full beat width.
   always_comb begin
      w_byte_inc = '0;
      if (w_xfer) begin
         if (KEEP_ENABLE) begin
            for (int i = 0; i < KEEP_WIDTH; i++)
               w_byte_inc = w_byte_inc + (CW+1)'(mon_axis_tkeep[i]);
         end else begin
            w_byte_inc = (CW+1)'(KEEP_WIDTH);
         end
      end
   end

   assign w_beat_sum  = f_sat_add(r_beat_acc,  (CW+1)'(w_xfer));
   assign w_byte_sum  = f_sat_add(r_byte_acc,  w_byte_inc);
   assign w_frame_sum = f_sat_add(r_frame_acc, (CW+1)'(w_frame));
   assign w_stall_sum = f_sat_add(r_stall_acc, (CW+1)'(w_stall));
   assign w_idle_sum  = f_sat_add(r_idle_acc,  (CW+1)'(w_idle));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state plus window start / accumulate / window end qualifiers.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_run       = 1'b0;
      w_win_end   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable && (period != '0)) begin
               w_start     = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (!enable) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_run = 1'b1;
               if (r_cnt == (r_period - PW'(1))) begin
                  w_win_end = 1'b1;
                  if (period == '0) w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Window counter, accumulators, snapshot registers and strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_period      <= '0;
         r_cnt         <= '0;
         r_beat_acc    <= '0;
         r_byte_acc    <= '0;
         r_frame_acc   <= '0;
         r_stall_acc   <= '0;
         r_idle_acc    <= '0;
         r_beat_snap   <= '0;
         r_byte_snap   <= '0;
         r_frame_snap  <= '0;
         r_stall_snap  <= '0;
         r_idle_snap   <= '0;
         r_count_valid <= 1'b0;
      end else begin
         r_count_valid <= w_win_end;
         if (w_start || w_win_end) r_period <= period;
         if (w_win_end) begin
            // The closing cycle's event belongs to the window being published.
            r_beat_snap  <= w_beat_sum;
            r_byte_snap  <= w_byte_sum;
            r_frame_snap <= w_frame_sum;
            r_stall_snap <= w_stall_sum;
            r_idle_snap  <= w_idle_sum;
         end
         if (w_run && !w_win_end) begin
            r_cnt       <= r_cnt + PW'(1);
            r_beat_acc  <= w_beat_sum;
            r_byte_acc  <= w_byte_sum;
            r_frame_acc <= w_frame_sum;
            r_stall_acc <= w_stall_sum;
            r_idle_acc  <= w_idle_sum;
         end else begin
            // Window boundary, idle, or aborted window: start from zero.
            r_cnt       <= '0;
            r_beat_acc  <= '0;
            r_byte_acc  <= '0;
            r_frame_acc <= '0;
            r_stall_acc <= '0;
            r_idle_acc  <= '0;
         end
      end
   end

   assign beat_count  = r_beat_snap;
   assign byte_count  = r_byte_snap;
   assign frame_count = r_frame_snap;
   assign stall_count = r_stall_snap;
   assign idle_count  = r_idle_snap;
   assign count_valid = r_count_valid;

`ifdef AXIS_RATE_METER_PEAK_EN
   logic [CW-1:0] r_peak;

   // Peak beats per window; a clear coinciding with a strobe keeps only the new window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_peak <= '0;
      end else if (w_win_end) begin
         if (clear_peak || (w_beat_sum > r_peak)) r_peak <= w_beat_sum;
      end else if (clear_peak) begin
         r_peak <= '0;
      end
   end

   assign peak_beat_count = r_peak;
`else
   assign peak_beat_count = '0;
`endif

endmodule

// File: tb/tb_axis_rate_meter.sv
`timescale 1ns/1ps
// Bench for axis_rate_meter: directed window table, hand sequences for abort/reset/halt,
// then randomized windows checked against per-window sums computed from the stimulus.
module tb_axis_rate_meter;

   localparam int KW   = 4;
   localparam int CW   = 6;
   localparam int PW   = 8;
   localparam int CMAX = 63;
`ifdef AXIS_RATE_METER_PEAK_EN
   localparam bit PK_EN = 1'b1;
`else
   localparam bit PK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [KW-1:0] mon_axis_tkeep;
   logic          mon_axis_tvalid, mon_axis_tready, mon_axis_tlast;
   logic          enable;
   logic [PW-1:0] period;
   logic [CW-1:0] beat_count, byte_count, frame_count, stall_count, idle_count, peak_beat_count;
   logic          count_valid;
   logic          clear_peak;

   always #5 clk = ~clk;

   axis_rate_meter #(
      .KEEP_WIDTH(KW), .KEEP_ENABLE(1'b1), .LAST_ENABLE(1'b1),
      .COUNT_WIDTH(CW), .PERIOD_WIDTH(PW)
   ) dut (
      .clk(clk), .rst(rst),
      .mon_axis_tkeep(mon_axis_tkeep), .mon_axis_tvalid(mon_axis_tvalid),
      .mon_axis_tready(mon_axis_tready), .mon_axis_tlast(mon_axis_tlast),
      .enable(enable), .period(period),
      .beat_count(beat_count), .byte_count(byte_count), .frame_count(frame_count),
      .stall_count(stall_count), .idle_count(idle_count), .count_valid(count_valid),
      .peak_beat_count(peak_beat_count), .clear_peak(clear_peak)
   );

   int n_checks = 0;
   int n_errors = 0;
   int pk = 0;   // expected peak

   bit         g_tv [256];
   bit         g_tr [256];
   bit         g_tl [256];
   logic [3:0] g_kp [256];

   typedef struct {
      bit start; int p; int mode; int p_next; int clr_at;
      int e_beat; int e_byte; int e_frame; int e_stall; int e_idle;
   } row_t;
   row_t tbl [16];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle stimulus for one window.
   task automatic gen(input int p, input int mode);
      for (int k = 0; k < p; k++) begin
         case (mode)
            0: begin g_tv[k] = 1; g_tr[k] = 1;          g_kp[k] = 4'hF; g_tl[k] = (k % 5 == 4); end
            1: begin g_tv[k] = 1; g_tr[k] = (k % 2 == 0); g_kp[k] = 4'h3; g_tl[k] = 0; end
            2: begin g_tv[k] = 0; g_tr[k] = 1;          g_kp[k] = 4'hF; g_tl[k] = 1; end
            3: begin g_tv[k] = 1; g_tr[k] = 1;          g_kp[k] = 4'hF; g_tl[k] = 0; end
            default: begin
               g_tv[k] = ($urandom_range(0, 3) != 0);
               g_tr[k] = 1'($urandom_range(0, 1));
               g_kp[k] = 4'($urandom);
               g_tl[k] = 1'($urandom_range(0, 1));
            end
         endcase
      end
   endtask

   // Called at the negedge where window cycle 0 is driven; returns at the negedge of the strobe.
   task automatic run_window(input int p, input int mode, input int p_next, input int clr_at,
                             input int e_beat, input int e_byte, input int e_frame,
                             input int e_stall, input int e_idle, input bit use_model);
      int eb, ey, ef, es, ei;
      gen(p, mode);
      if (use_model) begin
         eb = 0; ey = 0; ef = 0; es = 0; ei = 0;
         for (int k = 0; k < p; k++) begin
            if (!g_tv[k])      ei++;
            else if (!g_tr[k]) es++;
            else begin
               eb++;
               ey += $countones(g_kp[k]);
               if (g_tl[k]) ef++;
            end
         end
         if (eb > CMAX) eb = CMAX;
         if (ey > CMAX) ey = CMAX;
         if (ef > CMAX) ef = CMAX;
         if (es > CMAX) es = CMAX;
         if (ei > CMAX) ei = CMAX;
      end else begin
         eb = e_beat; ey = e_byte; ef = e_frame; es = e_stall; ei = e_idle;
      end
      for (int k = 0; k < p; k++) begin
         if (k > 0) begin
            @(negedge clk);
            chk("strobe_mid_window", int'(count_valid), 0);
            if (clr_at >= 0 && k == clr_at + 1) chk("peak_after_clear", int'(peak_beat_count), 0);
         end
         mon_axis_tvalid = g_tv[k];
         mon_axis_tready = g_tr[k];
         mon_axis_tkeep  = g_kp[k];
         mon_axis_tlast  = g_tl[k];
         period          = PW'(p_next);
         clear_peak      = (k == clr_at);
         if (k == clr_at && PK_EN) pk = 0;
      end
      @(negedge clk);
      clear_peak = 1'b0;
      chk("strobe_end",  int'(count_valid), 1);
      chk("beat_count",  int'(beat_count),  eb);
      chk("byte_count",  int'(byte_count),  ey);
      chk("frame_count", int'(frame_count), ef);
      chk("stall_count", int'(stall_count), es);
      chk("idle_count",  int'(idle_count),  ei);
      if (PK_EN) pk = (clr_at == p - 1) ? eb : ((eb > pk) ? eb : pk);
      chk("peak_beat_count", int'(peak_beat_count), pk);
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         if (tbl[i].start) begin
            enable = 1'b1;
            period = PW'(tbl[i].p);
            @(negedge clk);
         end
         run_window(tbl[i].p, tbl[i].mode, tbl[i].p_next, tbl[i].clr_at,
                    tbl[i].e_beat, tbl[i].e_byte, tbl[i].e_frame,
                    tbl[i].e_stall, tbl[i].e_idle, 1'b0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int p_cur, p_nxt;
      //          start p    mode next clr  beat byte frame stall idle
      tbl[0]  = '{1,   10,  0,   10,  -1,  10,  40,  2,    0,    0};
      tbl[1]  = '{0,   10,  0,   8,   -1,  10,  40,  2,    0,    0};
      tbl[2]  = '{0,   8,   1,   16,  -1,  4,   8,   0,    4,    0};
      tbl[3]  = '{0,   16,  2,   16,  -1,  0,   0,   0,    0,    16};
      tbl[4]  = '{1,   10,  0,   20,  -1,  10,  40,  2,    0,    0};
      tbl[5]  = '{0,   20,  0,   1,   -1,  20,  63,  4,    0,    0};
      tbl[6]  = '{0,   1,   0,   1,   -1,  1,   4,   0,    0,    0};
      tbl[7]  = '{0,   1,   2,   1,   -1,  0,   0,   0,    0,    1};
      tbl[8]  = '{0,   1,   1,   100, -1,  1,   2,   0,    0,    0};
      tbl[9]  = '{0,   100, 0,   6,   -1,  63,  63,  20,   0,    0};
      tbl[10] = '{1,   6,   3,   9,   -1,  6,   24,  0,    0,    0};
      tbl[11] = '{0,   9,   3,   3,   -1,  9,   36,  0,    0,    0};
      tbl[12] = '{0,   3,   3,   3,   -1,  3,   12,  0,    0,    0};
      tbl[13] = '{0,   3,   3,   9,   0,   3,   12,  0,    0,    0};
      tbl[14] = '{0,   9,   3,   3,   -1,  9,   36,  0,    0,    0};
      tbl[15] = '{0,   3,   3,   0,   2,   3,   12,  0,    0,    0};

      rst = 1'b1; enable = 1'b0; period = '0; clear_peak = 1'b0;
      mon_axis_tvalid = 1'b0; mon_axis_tready = 1'b0; mon_axis_tlast = 1'b0; mon_axis_tkeep = '0;
      repeat (3) @(negedge clk);
      chk("reset_beat",  int'(beat_count),  0);
      chk("reset_byte",  int'(byte_count),  0);
      chk("reset_frame", int'(frame_count), 0);
      chk("reset_stall", int'(stall_count), 0);
      chk("reset_idle",  int'(idle_count),  0);
      chk("reset_valid", int'(count_valid), 0);
      chk("reset_peak",  int'(peak_beat_count), 0);
      rst = 1'b0;
      @(negedge clk);

      run_rows(0, 3);

      // Abort a window at cycle 7: no strobe, snapshot holds the idle-16 result.
      for (int k = 0; k < 7; k++) begin
         if (k > 0) @(negedge clk);
         mon_axis_tvalid = 1'b0;
      end
      @(negedge clk);
      enable = 1'b0;
      repeat (20) begin
         @(negedge clk);
         chk("abort_no_strobe", int'(count_valid), 0);
         chk("abort_hold_idle", int'(idle_count), 16);
      end

      run_rows(4, 9);

      // Reset in the middle of a window.
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         mon_axis_tvalid = 1'b1; mon_axis_tready = 1'b1; mon_axis_tkeep = 4'hF;
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_beat",  int'(beat_count),  0);
      chk("midrst_byte",  int'(byte_count),  0);
      chk("midrst_frame", int'(frame_count), 0);
      chk("midrst_valid", int'(count_valid), 0);
      chk("midrst_peak",  int'(peak_beat_count), 0);
      pk = 0;
      @(negedge clk);
      chk("midrst_no_strobe", int'(count_valid), 0);
      enable = 1'b0;
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("postrst_no_strobe", int'(count_valid), 0);
      end

      run_rows(10, 15);

      // Window end with period=0 halts: no further strobes, snapshot holds.
      repeat (15) begin
         @(negedge clk);
         chk("halt_no_strobe", int'(count_valid), 0);
         chk("halt_hold_beat", int'(beat_count), 3);
      end

      // Randomized back-to-back windows.
      p_cur = $urandom_range(1, 12);
      enable = 1'b1;
      period = PW'(p_cur);
      @(negedge clk);
      for (int i = 0; i < 30; i++) begin
         p_nxt = (i == 29) ? 0 : $urandom_range(1, 12);
         run_window(p_cur, 4, p_nxt, -1, 0, 0, 0, 0, 0, 1'b1);
         p_cur = p_nxt;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
